// File: rtl/gb_fetch.sv
// gb_fetch: fetch stage that folds 0xCB prefixes and gathers immediates into one decoder bundle.
// Define GB_FETCH_PREFETCH_EN to fetch the next opcode byte into a 1-byte buffer while holding.
module gb_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        pc_load,
    input  logic [15:0] pc_load_val,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [7:0]  op,
    output logic        op_cb,
    output logic [15:0] imm,
    output logic [1:0]  imm_len,
    output logic [15:0] op_pc
);
    typedef enum logic [2:0] {FETCH_OP, FETCH_CB, FETCH_IMM_LO, FETCH_IMM_HI, HOLD} state_t;
    state_t state, nxt;
    logic [15:0] pc, src_pc;
    logic [7:0] src_byte;
    logic ack, take, op_go;
`ifdef GB_FETCH_PREFETCH_EN
    logic [7:0] pbuf;
    logic pbuf_v, pbuf_nv;
`endif

    function automatic logic [1:0] imm_bytes(input logic [7:0] b);
        case (b)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6, 8'hCE,
            8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE, 8'hE0, 8'hF0,
            8'hE8, 8'hF8: imm_bytes = 2'd1;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA,
            8'hD2, 8'hDA, 8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA,
            8'hFA: imm_bytes = 2'd2;
            default: imm_bytes = 2'd0;
        endcase
    endfunction

    assign mem_addr = pc;
    assign ack = mem_req & mem_ack;
    assign take = op_valid & op_ready;

    // op_go marks an opcode byte being decoded, either fresh from the bus or from the prefetch buffer
    always_comb begin
        op_go = 1'b0;
        src_byte = mem_rdata;
        src_pc = pc;
        nxt = state;
`ifdef GB_FETCH_PREFETCH_EN
        pbuf_nv = pbuf_v;
`endif
        case (state)
            FETCH_OP: op_go = ack;
            FETCH_CB, FETCH_IMM_HI: nxt = ack ? HOLD : state;
            FETCH_IMM_LO: nxt = ack ? (imm_len == 2'd2 ? FETCH_IMM_HI : HOLD) : state;
            default: if (take) begin
`ifdef GB_FETCH_PREFETCH_EN
                op_go = pbuf_v | ack;
                src_byte = pbuf_v ? pbuf : mem_rdata;
                src_pc = pbuf_v ? pc - 16'd1 : pc;
                pbuf_nv = 1'b0;
`endif
                nxt = FETCH_OP;
            end
`ifdef GB_FETCH_PREFETCH_EN
            else if (ack) pbuf_nv = 1'b1;
`endif
        endcase
        if (op_go) nxt = src_byte == 8'hCB ? FETCH_CB : imm_bytes(src_byte) != 2'd0 ? FETCH_IMM_LO : HOLD;
        if (pc_load) nxt = FETCH_OP;
`ifdef GB_FETCH_PREFETCH_EN
        if (pc_load) pbuf_nv = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_OP;
            pc <= RESET_PC;
            mem_req <= 1'b0;
            op_valid <= 1'b0;
            op <= 8'h00;
            op_cb <= 1'b0;
            imm <= 16'h0000;
            imm_len <= 2'd0;
            op_pc <= 16'h0000;
`ifdef GB_FETCH_PREFETCH_EN
            pbuf <= 8'h00;
            pbuf_v <= 1'b0;
`endif
        end else begin
            state <= nxt;
            op_valid <= nxt == HOLD;
`ifdef GB_FETCH_PREFETCH_EN
            mem_req <= nxt != HOLD || !pbuf_nv;
            pbuf_v <= pbuf_nv;
            if (state == HOLD && ack && !take) pbuf <= mem_rdata;
`else
            mem_req <= nxt != HOLD;
`endif
            if (pc_load) begin
                pc <= pc_load_val;
                op_cb <= 1'b0;
                imm <= 16'h0000;
            end else begin
                if (ack) pc <= pc + 16'd1;
                if (op_go) begin
                    op_pc <= src_pc;
                    op <= src_byte;
                    op_cb <= 1'b0;
                    imm <= 16'h0000;
                    imm_len <= imm_bytes(src_byte);
                end else if (state == HOLD && take) begin
                    op_cb <= 1'b0;
                    imm <= 16'h0000;
                end
                if (ack) begin
                    case (state)
                        FETCH_CB: begin
                            op <= mem_rdata;
                            op_cb <= 1'b1;
                            imm_len <= 2'd0;
                        end
                        FETCH_IMM_LO: imm <= {8'h00, mem_rdata};
                        FETCH_IMM_HI: imm[15:8] <= mem_rdata;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
